// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        SWITCH,
        DONE
    } state_t;

    typedef enum logic {
        GNT_INSTR,
        GNT_DATA
    } grant_t;

    // Read data returned to the CPU when an access is aborted on timeout.
    localparam int unsigned ABORT_RDATA = 0;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter for a memory access; flags the cycle whose increment reaches TIMEOUT.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != CNT_W'(TIMEOUT))) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Asserted in the TIMEOUT-th waiting cycle so the abort lands after exactly TIMEOUT cycles.
    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU fetch, load and store accesses onto one request/acknowledge memory bus.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_read,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_ready,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_ready,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    state_t            state_q, state_d;
    grant_t            grant_q, grant_d;
    grant_t            last_grant_q, last_grant_d;
    grant_t            gnt;
    logic              pend_i_q, pend_i_d;
    logic              pend_d_q, pend_d_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              instr_ready_q, instr_ready_d;
    logic              data_ready_q, data_ready_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] rdata;
    logic              data_req;
    logic              any_req;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_expired;

    assign data_req = data_read | data_write;
    assign any_req  = instr_read | data_req;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        pend_i_d      = pend_i_q;
        pend_d_d      = pend_d_q;
        we_d          = we_q;
        iaddr_d       = iaddr_q;
        daddr_d       = daddr_q;
        wdata_d       = wdata_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        instr_out_d   = instr_out_q;
        data_out_d    = data_out_q;
        instr_ready_d = 1'b0;
        data_ready_d  = 1'b0;
        bus_err_d     = 1'b0;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        gnt           = GNT_INSTR;
        rdata         = '0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    pend_i_d = instr_read;
                    pend_d_d = data_req;
                    we_d     = data_write;
                    iaddr_d  = instr_addr;
                    daddr_d  = data_addr;
                    wdata_d  = data_in;
                    // Only a genuine conflict consults the round-robin pointer.
                    if (instr_read && data_req) begin
                        gnt = (last_grant_q == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
                    end else begin
                        gnt = instr_read ? GNT_INSTR : GNT_DATA;
                    end
                    grant_d      = gnt;
                    last_grant_d = gnt;
                    mem_req_d    = 1'b1;
                    mem_we_d     = (gnt == GNT_DATA) && data_write;
                    mem_addr_d   = (gnt == GNT_DATA) ? data_addr : instr_addr;
                    mem_wdata_d  = data_in;
                    tmr_clr      = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack || tmr_expired) begin
                    rdata     = mem_ack ? mem_rdata : DATA_W'(ABORT_RDATA);
                    bus_err_d = !mem_ack;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (grant_q == GNT_INSTR) begin
                        instr_out_d   = rdata;
                        instr_ready_d = 1'b1;
                        pend_i_d      = 1'b0;
                        state_d       = pend_d_q ? SWITCH : DONE;
                    end else begin
                        if (!we_q) begin
                            data_out_d = rdata;
                        end
                        data_ready_d = 1'b1;
                        pend_d_d     = 1'b0;
                        state_d      = pend_i_q ? SWITCH : DONE;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            SWITCH: begin
                gnt         = pend_i_q ? GNT_INSTR : GNT_DATA;
                grant_d     = gnt;
                mem_req_d   = 1'b1;
                mem_we_d    = (gnt == GNT_DATA) && we_q;
                mem_addr_d  = (gnt == GNT_DATA) ? daddr_q : iaddr_q;
                mem_wdata_d = wdata_q;
                tmr_clr     = 1'b1;
                state_d     = BUSY;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= GNT_INSTR;
            last_grant_q  <= GNT_INSTR;
            pend_i_q      <= 1'b0;
            pend_d_q      <= 1'b0;
            we_q          <= 1'b0;
            iaddr_q       <= '0;
            daddr_q       <= '0;
            wdata_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            instr_out_q   <= '0;
            data_out_q    <= '0;
            instr_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            pend_i_q      <= pend_i_d;
            pend_d_q      <= pend_d_d;
            we_q          <= we_d;
            iaddr_q       <= iaddr_d;
            daddr_q       <= daddr_d;
            wdata_q       <= wdata_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            instr_out_q   <= instr_out_d;
            data_out_q    <= data_out_d;
            instr_ready_q <= instr_ready_d;
            data_ready_q  <= data_ready_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // Gated by rst so the stall drops with the rest of the outputs during reset.
    assign cpu_stall = !rst && (((state_q == IDLE) && any_req) ||
                                (state_q == BUSY) || (state_q == SWITCH));

    assign instr_out   = instr_out_q;
    assign instr_ready = instr_ready_q;
    assign data_out    = data_out_q;
    assign data_ready  = data_ready_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign bus_err     = bus_err_q;

endmodule
